operand_skid_buffer: RTL and testbench

- Two-entry valid/ready pipeline register that captures the 16-bit selected operand from the multiplexer16bit stage and presents it to the ALU/register-write stage.
- Decouples the combinational mux output from downstream back-pressure:
  - full throughput of one word per cycle;
  - a registered `in_ready` with no combinational ready path through the block;
  - `out_data` held stable while stalled.

---
 rtl/operand_skid_if.sv | 23 ++
 rtl/operand_skid_buffer.sv | 93 +++++++++
 tb/tb_operand_skid_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/operand_skid_if.sv
// Valid/ready handshake bundle between the operand mux and the ALU/register-write stage.
interface operand_skid_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       occupancy;

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/operand_skid_buffer.sv
// Two-entry skid buffer: main register M drives the output, S absorbs one word when M stalls.
module operand_skid_buffer #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  operand_skid_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] s_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [1:0]       occupancy_reg;

  logic accept;
  logic drain;

  // Handshakes use only registered status, so no combinational ready/valid path crosses the block.
  assign accept = bus.in_valid & in_ready_reg;
  assign drain  = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      m_reg         <= '0;
      s_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      occupancy_reg <= 2'd0;
    end else if (bus.flush) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      occupancy_reg <= 2'd0;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_reg         <= bus.in_data;
            state_reg     <= ONE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b1;
            occupancy_reg <= 2'd1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_reg <= bus.in_data;
          end else if (accept) begin
            // M is stalled: park the new word behind it.
            s_reg         <= bus.in_data;
            state_reg     <= TWO;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            occupancy_reg <= 2'd2;
          end else if (drain) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            occupancy_reg <= 2'd0;
          end
        end
        TWO: begin
          if (drain) begin
            m_reg         <= s_reg;
            state_reg     <= ONE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b1;
            occupancy_reg <= 2'd1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          occupancy_reg <= 2'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = m_reg;
  assign bus.occupancy = occupancy_reg;
endmodule

// File: tb/tb_operand_skid_buffer.sv
// Directed and randomised checks of operand_skid_buffer against a queue-based FIFO model.
module tb_operand_skid_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  operand_skid_if #(.WIDTH(16)) bus ();

  operand_skid_buffer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  task automatic compare_model();
    int n;
    n = model_q.size();
    check("in_ready", 32'(bus.in_ready), 32'(n < 2));
    check("out_valid", 32'(bus.out_valid), 32'(n > 0));
    check("occupancy", 32'(bus.occupancy), 32'(n));
    if (n > 0) check("out_data", 32'(bus.out_data), 32'(model_q[0]));
  endtask

  // One clock: the model applies FIFO rules to the inputs present before the edge.
  task automatic tick();
    logic v, r, f, hold;
    logic [15:0] d, prev_data;
    int n;
    v = bus.in_valid; r = bus.out_ready; f = bus.flush; d = bus.in_data;
    n = model_q.size();
    hold = bus.out_valid && !r && !f;
    prev_data = bus.out_data;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (r && n > 0) void'(model_q.pop_front());
      if (v && n < 2) model_q.push_back(d);
    end
    #1;
    compare_model();
    if (hold) begin
      check("stall_data", 32'(bus.out_data), 32'(prev_data));
      check("stall_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_occupancy", 32'(bus.occupancy), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      tick();
      check("stream_data", 32'(bus.out_data), 32'(i));
      check("stream_occ", 32'(bus.occupancy), 32'd1);
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();

    // Back-pressure and restart
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h5555, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h1234, 1'b0, 1'b0); tick();
    check("bp_occ", 32'(bus.occupancy), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_held", 32'(bus.out_data), 32'hAAAA);
    tick();
    check("bp_still_held", 32'(bus.out_data), 32'hAAAA);
    drive(1'b1, 16'h1234, 1'b1, 1'b0); tick();
    check("bp_second", 32'(bus.out_data), 32'h5555);
    check("bp_restart_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_reoffer", 32'(bus.out_data), 32'h1234);
    drive(1'b0, 16'h0, 1'b1, 1'b0); tick();

    // Simultaneous accept and drain in ONE
    drive(1'b1, 16'h00FF, 1'b1, 1'b0); tick();
    drive(1'b1, 16'hFF00, 1'b1, 1'b0); tick();
    check("swap_data", 32'(bus.out_data), 32'hFF00);
    check("swap_occ", 32'(bus.occupancy), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0); tick();

    // Flush at occupancy 2 with a word offered
    drive(1'b1, 16'h1111, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h2222, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hBEEF, 1'b0, 1'b1); tick();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_occ", 32'(bus.occupancy), 32'd0);
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_beef", 32'(bus.out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream at occupancy 2
    drive(1'b1, 16'hC0DE, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hD00D, 1'b0, 1'b0); tick();
    check("pre_reset_occ", 32'(bus.occupancy), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    check("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check("areset_in_ready", 32'(bus.in_ready), 32'd1);
    check("areset_occ", 32'(bus.occupancy), 32'd0);
    check("areset_out_data", 32'(bus.out_data), 32'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomised valid/ready with occasional flush
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
      tick();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();
    check("final_empty", 32'(bus.occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
